// File: rtl/pm_loader_ctrl.sv
// pm_loader_ctrl
// Streams a program into a CPU's program memory over a valid/ready
// handshake, holds the CPU in reset for a short boot window, then lets it
// free-run or single-step until it reports that the halt opcode retired.
//
// Ports
//   CLK, RESET          clock and synchronous active-high reset
//   I_START_LOAD        begin a new load (honoured in IDLE and HALT only)
//   I_DATA_VALID/I_DATA incoming program word
//   I_MODE              0 = free run, 1 = single step (sampled at end of boot)
//   I_STEP              single-step request, one CPU cycle per rising edge
//   I_HALT_DETECT       CPU reports the halt opcode retired
//   O_DATA_READY        high while loading; word accepted when also valid
//   O_PM_WE/ADDR/WDATA  program-memory write port, one cycle after accept
//   O_CPU_RESET/O_CPU_EN CPU reset and clock enable
//   O_STATE             IDLE=0 LOAD=1 BOOT=2 RUN=3 STEP=4 HALT=5
//   O_WORD_COUNT        words written in the current load
//   O_CYCLE_COUNT       saturating count of CPU-enabled cycles since load start
//   O_LOAD_ERR          memory filled without seeing the halt word
module pm_loader_ctrl #(
  parameter int                DATA_W      = 32,
  parameter int                DEPTH       = 32,
  parameter logic [DATA_W-1:0] HALT_WORD   = 32'hFFFFFFFF,
  parameter int                BOOT_CYCLES = 2,
  localparam int               ADDR_W      = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              I_START_LOAD,
  input  logic              I_DATA_VALID,
  input  logic [DATA_W-1:0] I_DATA,
  input  logic              I_MODE,
  input  logic              I_STEP,
  input  logic              I_HALT_DETECT,
  output logic              O_DATA_READY,
  output logic              O_PM_WE,
  output logic [ADDR_W-1:0] O_PM_ADDR,
  output logic [DATA_W-1:0] O_PM_WDATA,
  output logic              O_CPU_RESET,
  output logic              O_CPU_EN,
  output logic [2:0]        O_STATE,
  output logic [ADDR_W:0]   O_WORD_COUNT,
  output logic [31:0]       O_CYCLE_COUNT,
  output logic              O_LOAD_ERR
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_BOOT = 3'd2,
    S_RUN  = 3'd3,
    S_STEP = 3'd4,
    S_HALT = 3'd5
  } state_t;

  localparam logic [ADDR_W:0] LAST_IDX  = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [3:0]      BOOT_LAST = 4'(BOOT_CYCLES - 1);

  state_t              state_q, state_d;
  logic                pm_we_q, pm_we_d;
  logic [ADDR_W-1:0]   pm_addr_q, pm_addr_d;
  logic [DATA_W-1:0]   pm_wdata_q, pm_wdata_d;
  logic [ADDR_W:0]     word_cnt_q, word_cnt_d;
  logic [31:0]         cycle_cnt_q, cycle_cnt_d;
  logic                load_err_q, load_err_d;
  logic [3:0]          boot_cnt_q, boot_cnt_d;
  logic                step_q, step_d;        // previous I_STEP sample
  logic                pulse_q, pulse_d;      // one-cycle step enable
  logic                accept;
  logic                cpu_en;

  assign accept = (state_q == S_LOAD) && I_DATA_VALID;
  assign cpu_en = (state_q == S_RUN) || ((state_q == S_STEP) && pulse_q);

  always_comb begin
    state_d     = state_q;
    pm_we_d     = 1'b0;
    pm_addr_d   = pm_addr_q;
    pm_wdata_d  = pm_wdata_q;
    word_cnt_d  = word_cnt_q;
    cycle_cnt_d = cycle_cnt_q;
    load_err_d  = load_err_q;
    boot_cnt_d  = boot_cnt_q;
    step_d      = I_STEP;
    pulse_d     = 1'b0;

    if (accept) begin
      pm_we_d    = 1'b1;
      pm_addr_d  = word_cnt_q[ADDR_W-1:0];
      pm_wdata_d = I_DATA;
      word_cnt_d = word_cnt_q + 1'b1;
    end

    if (cpu_en && (cycle_cnt_q != 32'hFFFFFFFF)) begin
      cycle_cnt_d = cycle_cnt_q + 32'd1;
    end

    case (state_q)
      S_IDLE, S_HALT: begin
        if (I_START_LOAD) begin
          state_d     = S_LOAD;
          word_cnt_d  = '0;
          cycle_cnt_d = '0;
          load_err_d  = 1'b0;
        end
      end
      S_LOAD: begin
        // The halt word is checked first so a halt word landing in the
        // last slot is a clean load rather than a truncation.
        if (accept) begin
          if (I_DATA == HALT_WORD) begin
            state_d    = S_BOOT;
            boot_cnt_d = '0;
          end else if (word_cnt_q == LAST_IDX) begin
            state_d    = S_BOOT;
            boot_cnt_d = '0;
            load_err_d = 1'b1;
          end
        end
      end
      S_BOOT: begin
        if (boot_cnt_q == BOOT_LAST) begin
          state_d = I_MODE ? S_STEP : S_RUN;
        end else begin
          boot_cnt_d = boot_cnt_q + 4'd1;
        end
      end
      S_RUN: begin
        if (I_HALT_DETECT) state_d = S_HALT;
      end
      S_STEP: begin
        // Halt takes precedence over a coincident step edge.
        if (I_HALT_DETECT) begin
          state_d = S_HALT;
        end else if (I_STEP && !step_q) begin
          pulse_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      pm_we_q     <= 1'b0;
      pm_addr_q   <= '0;
      pm_wdata_q  <= '0;
      word_cnt_q  <= '0;
      cycle_cnt_q <= '0;
      load_err_q  <= 1'b0;
      boot_cnt_q  <= '0;
      step_q      <= 1'b0;
      pulse_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pm_we_q     <= pm_we_d;
      pm_addr_q   <= pm_addr_d;
      pm_wdata_q  <= pm_wdata_d;
      word_cnt_q  <= word_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
      load_err_q  <= load_err_d;
      boot_cnt_q  <= boot_cnt_d;
      step_q      <= step_d;
      pulse_q     <= pulse_d;
    end
  end

  assign O_DATA_READY  = (state_q == S_LOAD);
  assign O_PM_WE       = pm_we_q;
  assign O_PM_ADDR     = pm_addr_q;
  assign O_PM_WDATA    = pm_wdata_q;
  assign O_CPU_RESET   = (state_q == S_IDLE) || (state_q == S_LOAD) || (state_q == S_BOOT);
  assign O_CPU_EN      = cpu_en;
  assign O_STATE       = state_q;
  assign O_WORD_COUNT  = word_cnt_q;
  assign O_CYCLE_COUNT = cycle_cnt_q;
  assign O_LOAD_ERR    = load_err_q;

endmodule

// File: doc/pm_loader_ctrl.md
PM_LOADER_CTRL -- requirements
Module: pm_loader_ctrl

Parameters
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the program word width.
REQ-002 The block SHALL have parameter DEPTH, default 32, giving the number of program-memory words; ADDR_W = clog2(DEPTH).
REQ-003 The block SHALL have parameter HALT_WORD, default 32'hFFFFFFFF, giving the program terminator and CPU halt opcode.
REQ-004 The block SHALL have parameter BOOT_CYCLES, default 2, giving the CPU reset hold after load (range 1..15).

Interface
REQ-005 CLK  in  1  single clock; all state updates on its rising edge.
REQ-006 RESET  in  1  reset; synchronous, active-high.
REQ-007 I_START_LOAD  in  1  request a new program load.
REQ-008 I_DATA_VALID  in  1  I_DATA holds a program word.
REQ-009 I_DATA  in  DATA_W  program word.
REQ-010 I_MODE  in  1  0 = free run, 1 = single step.
REQ-011 I_STEP  in  1  step request; its rising edge grants one CPU cycle.
REQ-012 I_HALT_DETECT  in  1  CPU reports that HALT_WORD retired.
REQ-013 O_DATA_READY  out  1  word accepted this cycle if I_DATA_VALID is high.
REQ-014 O_PM_WE, O_PM_ADDR, O_PM_WDATA  out  1/ADDR_W/DATA_W  program-memory write port.
REQ-015 O_CPU_RESET, O_CPU_EN  out  1/1  CPU reset and clock enable.
REQ-016 O_STATE  out  3  IDLE=0, LOAD=1, BOOT=2, RUN=3, STEP=4, HALT=5.
REQ-017 O_WORD_COUNT  out  ADDR_W+1  words written in the current load.
REQ-018 O_CYCLE_COUNT  out  32  CPU-enabled cycles since load start.
REQ-019 O_LOAD_ERR  out  1  program truncated: DEPTH words received and none was HALT_WORD.

Function
REQ-020 Handshake: O_DATA_READY SHALL be 1 iff state==LOAD; a word is accepted when O_DATA_READY and I_DATA_VALID are both 1.
REQ-021 Write timing: an accepted word SHALL appear on O_PM_WE=1, O_PM_ADDR=O_WORD_COUNT (pre-increment), O_PM_WDATA=I_DATA in the next cycle only.
REQ-022 Word count: O_WORD_COUNT SHALL increment by 1 per accepted word.
REQ-023 IDLE: I_START_LOAD SHALL go to LOAD and clear O_WORD_COUNT, O_CYCLE_COUNT and O_LOAD_ERR.
REQ-024 LOAD: accepting HALT_WORD SHALL go to BOOT; that word is still written.
REQ-025 LOAD: accepting the DEPTH-th word when it is not HALT_WORD SHALL go to BOOT and set O_LOAD_ERR.
REQ-026 LOAD: if the DEPTH-th word is HALT_WORD, the block SHALL go to BOOT with O_LOAD_ERR=0.
REQ-027 BOOT: the block SHALL stay exactly BOOT_CYCLES cycles, then go to RUN if I_MODE=0, or STEP if I_MODE=1, with I_MODE sampled in the last BOOT cycle.
REQ-028 O_CPU_RESET SHALL be 1 in IDLE, LOAD and BOOT, and 0 in RUN, STEP and HALT.
REQ-029 RUN: O_CPU_EN SHALL be 1 every cycle.
REQ-030 STEP: I_STEP SHALL be registered; a 0->1 transition SHALL produce O_CPU_EN=1 for exactly one cycle, the cycle after the edge is sampled; held-high I_STEP SHALL produce no further pulses.
REQ-031 I_HALT_DETECT in RUN or STEP SHALL go to HALT; O_CPU_EN SHALL be 0 from the next cycle.
REQ-032 If an I_STEP edge and I_HALT_DETECT arrive in the same cycle, halt SHALL win and no step pulse SHALL be issued.
REQ-033 HALT: O_CPU_EN SHALL be 0; I_START_LOAD SHALL go to LOAD with the same clears as REQ-023.
REQ-034 I_START_LOAD SHALL be ignored in LOAD, BOOT, RUN and STEP.
REQ-035 O_CYCLE_COUNT SHALL increment on every cycle with O_CPU_EN=1 and SHALL saturate at 32'hFFFFFFFF.

Reset
REQ-036 While RESET=1 at a rising edge, the block SHALL force:
- state=IDLE
- O_PM_WE=0, O_PM_ADDR=0, O_PM_WDATA=0
- O_WORD_COUNT=0, O_CYCLE_COUNT=0, O_LOAD_ERR=0
- O_CPU_EN=0, O_CPU_RESET=1, O_DATA_READY=0
- step-edge register=0
REQ-037 RESET SHALL take priority over all other inputs in any state, including a write pending in the same cycle, which SHALL be dropped.

Verification
REQ-038 Load: start load, send 0x20080005, 0x20090003, HALT_WORD with valid held -> three WE pulses at addresses 0,1,2; O_WORD_COUNT=3; BOOT for 2 cycles; then RUN with O_CPU_RESET=0.
REQ-039 Truncation: send 32 non-halt words -> 32nd write at address 31, O_LOAD_ERR=1, O_DATA_READY=0 in the following cycle.
REQ-040 Step mode: I_MODE=1, I_STEP toggled 4 times, one edge held high for 5 cycles -> exactly 4 O_CPU_EN pulses, O_CYCLE_COUNT=4.
REQ-041 Halt: I_HALT_DETECT in RUN after 10 enabled cycles -> HALT, O_CYCLE_COUNT=10, O_CPU_EN=0; a coincident I_STEP edge in STEP produces no pulse.
REQ-042 Reset mid-load: RESET asserted after 2 accepted words -> IDLE, all outputs at reset values, no further WE; a fresh load starts at address 0.
REQ-043 Reload: I_START_LOAD in HALT -> LOAD, all counters cleared, O_CPU_RESET=1.
